// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch with in-flight PC queue, 2-entry buffer and redirect drop counter
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] rq0_q, rq0_d, rq1_q, rq1_d;
    logic [1:0]  rq_cnt_q, rq_cnt_d;
    logic [31:0] bw0_q, bw0_d, bw1_q, bw1_d;
    logic [31:0] bp0_q, bp0_d, bp1_q, bp1_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;
    logic [1:0]  drop_q, drop_d;

    logic        buf_pop;
    logic        rsp_take;
    logic        rsp_keep;
    logic        req_accept;
    logic [2:0]  occ_after_pop;

    // Handshake decode; a buffer slot freed by this cycle's pop counts as free so fetch streams at one per cycle
    always_comb begin
        buf_pop        = (buf_cnt_q != 2'd0) && instr_ready && !redirect_valid;
        occ_after_pop  = {1'b0, rq_cnt_q} + {1'b0, buf_cnt_q} - {2'b00, buf_pop};
        imem_req_valid = !rst && !redirect_valid && (occ_after_pop < 3'd2);
        req_accept     = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && (rq_cnt_q != 2'd0);
        rsp_keep       = rsp_take && (drop_q == 2'd0) && !redirect_valid;
    end

    // Next-state: request-PC queue, instruction buffer, drop counter and fetch PC
    always_comb begin
        pc_d      = pc_q;
        rq0_d     = rq0_q;
        rq1_d     = rq1_q;
        rq_cnt_d  = rq_cnt_q;
        bw0_d     = bw0_q;
        bw1_d     = bw1_q;
        bp0_d     = bp0_q;
        bp1_d     = bp1_q;
        buf_cnt_d = buf_cnt_q;
        drop_d    = drop_q;

        if (rsp_take) begin
            rq0_d    = rq1_q;
            rq_cnt_d = rq_cnt_q - 2'd1;
        end
        if (req_accept) begin
            if (rq_cnt_d == 2'd0) begin
                rq0_d = pc_q;
            end else begin
                rq1_d = pc_q;
            end
            rq_cnt_d = rq_cnt_d + 2'd1;
        end

        if (buf_pop) begin
            bw0_d     = bw1_q;
            bp0_d     = bp1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (rsp_keep) begin
            if (buf_cnt_d == 2'd0) begin
                bw0_d = imem_rsp_data;
                bp0_d = rq0_q;
            end else begin
                bw1_d = imem_rsp_data;
                bp1_d = rq0_q;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end

        // No request is accepted in a redirect cycle, so rq_cnt_d is the surviving in-flight count
        if (redirect_valid) begin
            buf_cnt_d = 2'd0;
            drop_d    = rq_cnt_d;
        end else if (rsp_take && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end

        if (redirect_valid) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (req_accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            rq0_q     <= 32'd0;
            rq1_q     <= 32'd0;
            rq_cnt_q  <= 2'd0;
            bw0_q     <= 32'd0;
            bw1_q     <= 32'd0;
            bp0_q     <= 32'd0;
            bp1_q     <= 32'd0;
            buf_cnt_q <= 2'd0;
            drop_q    <= 2'd0;
        end else begin
            pc_q      <= pc_d;
            rq0_q     <= rq0_d;
            rq1_q     <= rq1_d;
            rq_cnt_q  <= rq_cnt_d;
            bw0_q     <= bw0_d;
            bw1_q     <= bw1_d;
            bp0_q     <= bp0_d;
            bp1_q     <= bp1_d;
            buf_cnt_q <= buf_cnt_d;
            drop_q    <= drop_d;
        end
    end

    // Decoder-side outputs show the buffer head, forced quiet while reset is held
    always_comb begin
        instr_valid   = !rst && (buf_cnt_q != 2'd0);
        instr         = instr_valid ? bw0_q : 32'd0;
        instr_pc      = instr_valid ? bp0_q : 32'd0;
        imem_req_addr = rst ? RESET_PC : pc_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a sequence-level fetch model
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    logic        req2_valid, req2_ready;
    logic [31:0] req2_addr;
    logic        rsp2_valid;
    logic [31:0] rsp2_data;
    logic        redir2_valid;
    logic [31:0] redir2_pc;
    logic        instr2_valid, instr2_ready;
    logic [31:0] instr2, instr2_pc;

    instr_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req2_valid), .imem_req_ready(req2_ready), .imem_req_addr(req2_addr),
        .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
        .redirect_valid(redir2_valid), .redirect_pc(redir2_pc),
        .instr_valid(instr2_valid), .instr_ready(instr2_ready), .instr(instr2), .instr_pc(instr2_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          failures = 0;
    mreq_t       memq[$];
    logic [31:0] dut2q[$];
    int          cyc = 0;
    int          n_acc = 0;
    int          n_cons = 0;
    logic [31:0] exp_pc, exp_req;
    bit          flush_pending;
    int          rdy_pct, irdy_pct, rsp_pct, redir_pct, min_dly, max_dly;
    bit          force_redir;
    logic [31:0] force_pc;
    logic        acc2_prev;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic cyc_begin();
        imem_req_ready = roll(rdy_pct);
        instr_ready    = roll(irdy_pct);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = roll(redir_pct);
            redirect_pc    = roll(30) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom();
        end
        if (memq.size() > 0 && memq[0].due <= cyc && roll(rsp_pct)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        rsp2_valid = acc2_prev;
        #1;
    endtask

    task automatic cyc_end();
        mreq_t m;
        if (flush_pending) begin
            chk1("flush_after_redirect", instr_valid, 1'b0);
            flush_pending = 1'b0;
        end
        if (imem_rsp_valid) void'(memq.pop_front());
        if (redirect_valid) chk1("no_req_in_redirect", imem_req_valid, 1'b0);
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            m.addr = imem_req_addr;
            m.due  = cyc + int'($urandom_range(min_dly, max_dly));
            memq.push_back(m);
            exp_req = exp_req + 32'd4;
            n_acc++;
            chk1("inflight_le_2", memq.size() <= 2, 1'b1);
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr_word", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_cons++;
        end
        if (redirect_valid) begin
            exp_pc        = redirect_pc & 32'hFFFF_FFFC;
            exp_req       = redirect_pc & 32'hFFFF_FFFC;
            flush_pending = 1'b1;
        end
        if (dut2q.size() < 3 && req2_valid) dut2q.push_back(req2_addr);
        acc2_prev = req2_valid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        rsp2_valid     = 1'b0;
        acc2_prev      = 1'b0;
        force_redir    = 1'b0;
        #1;
        chk1("rst_req_valid_now", imem_req_valid, 1'b0);
        chk1("rst_instr_valid_now", instr_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);
        chk("rst_req_addr2", req2_addr, 32'hFFFF_FFF8);
        memq.delete();
        dut2q.delete();
        exp_pc        = 32'd0;
        exp_req       = 32'd0;
        flush_pending = 1'b0;
        rst           = 1'b0;
    endtask

    initial begin
        int          n0;
        int          a0;
        bit          got;
        logic [31:0] gv;

        req2_ready   = 1'b1;
        instr2_ready = 1'b1;
        redir2_valid = 1'b0;
        redir2_pc    = 32'd0;
        rsp2_data    = 32'd0;
        rdy_pct = 100; irdy_pct = 100; rsp_pct = 100; redir_pct = 0; min_dly = 1; max_dly = 1;
        force_pc = 32'd0;

        // Reset release, streaming fetch
        do_reset();
        cyc_begin();
        chk1("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 32'd0);
        cyc_end();
        cyc_begin();
        chk1("c1_instr_valid", instr_valid, 1'b0);
        chk("c1_req_addr", imem_req_addr, 32'd4);
        cyc_end();
        cyc_begin();
        chk1("c2_instr_valid", instr_valid, 1'b1);
        chk("c2_instr_pc", instr_pc, 32'd0);
        chk("c2_req_addr", imem_req_addr, 32'd8);
        cyc_end();
        n0 = n_cons;
        run(20);
        chk("throughput_20", 32'(n_cons - n0), 32'd20);

        // Wrapping reset PC on the second instance
        chk1("dut2_three_reqs", dut2q.size() >= 3, 1'b1);
        if (dut2q.size() >= 3) begin
            chk("dut2_addr0", dut2q[0], 32'hFFFF_FFF8);
            chk("dut2_addr1", dut2q[1], 32'hFFFF_FFFC);
            chk("dut2_addr2", dut2q[2], 32'h0000_0000);
        end

        // Decoder stall
        do_reset();
        irdy_pct = 0;
        a0 = n_acc;
        run(10);
        chk("stall_accepts", 32'(n_acc - a0), 32'd2);
        chk1("stall_instr_valid", instr_valid, 1'b1);
        chk("stall_instr_pc", instr_pc, 32'd0);
        irdy_pct = 100;
        cyc_begin();
        chk1("resume_req_valid", imem_req_valid, 1'b1);
        chk("resume_req_addr", imem_req_addr, 32'd8);
        cyc_end();
        run(10);

        // Redirect with two requests in flight
        do_reset();
        min_dly = 3; max_dly = 3;
        run(2);
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        cyc_begin();
        chk1("redir_cycle_req", imem_req_valid, 1'b0);
        cyc_end();
        got = 1'b0; gv = 32'd0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc_begin();
            if (imem_req_valid && imem_req_ready) begin got = 1'b1; gv = imem_req_addr; end
            cyc_end();
        end
        chk1("redir_req_seen", got, 1'b1);
        chk("redir_req_addr", gv, 32'h0000_0100);
        got = 1'b0; gv = 32'd0;
        for (int i = 0; i < 12 && !got; i++) begin
            cyc_begin();
            if (instr_valid) begin got = 1'b1; gv = instr_pc; end
            cyc_end();
        end
        chk1("redir_instr_seen", got, 1'b1);
        chk("redir_instr_pc", gv, 32'h0000_0100);

        // Redirect colliding with a response and instr_ready, then back-to-back redirects
        do_reset();
        min_dly = 1; max_dly = 1;
        run(5);
        force_redir = 1'b1; force_pc = 32'h0000_2000;
        cyc_begin();
        chk1("collide_valid_before", instr_valid, 1'b1);
        chk1("collide_rsp_present", imem_rsp_valid, 1'b1);
        chk1("collide_no_req", imem_req_valid, 1'b0);
        cyc_end();
        cyc_begin();
        chk1("collide_flushed", instr_valid, 1'b0);
        cyc_end();
        force_redir = 1'b1; force_pc = 32'h0000_3000;
        run(1);
        force_redir = 1'b1; force_pc = 32'h0000_4009;
        run(1);
        got = 1'b0; gv = 32'd0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc_begin();
            if (instr_valid) begin got = 1'b1; gv = instr_pc; end
            cyc_end();
        end
        chk1("b2b_instr_seen", got, 1'b1);
        chk("b2b_instr_pc", gv, 32'h0000_4008);

        // Randomized traffic against the model, including a mid-run reset
        do_reset();
        rdy_pct = 60; irdy_pct = 70; rsp_pct = 70; redir_pct = 3; min_dly = 1; max_dly = 3;
        n0 = n_cons;
        run(3000);
        chk1("random_progress", (n_cons - n0) > 100, 1'b1);
        do_reset();
        n0 = n_cons;
        run(1500);
        chk1("random_progress_after_reset", (n_cons - n0) > 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
